// File: rtl/estirador_pulso_if.sv
// Signal bundle for the pulse stretcher: trigger and timing inputs from the
// producer side, stretched pulse and status strobes back to it.
interface estirador_pulso_if #(
    parameter int ANCHO_W = 8
);
    logic               Disparo;
    logic [ANCHO_W-1:0] Duracion;
    logic [ANCHO_W-1:0] Separacion;
    logic               Salida;
    logic               Ocupado;
    logic               Fin;
    logic               Perdido;

    // Producer drives trigger and timing, observes the stretched pulse.
    modport master (
        output Disparo, Duracion, Separacion,
        input  Salida, Ocupado, Fin, Perdido
    );

    // The stretcher itself.
    modport slave (
        input  Disparo, Duracion, Separacion,
        output Salida, Ocupado, Fin, Perdido
    );
endinterface

// File: rtl/estirador_pulso.sv
// Pulse stretcher: turns single-cycle triggers into level pulses of
// Duracion cycles, each followed by a low gap of max(Separacion,1) cycles.
// Triggers arriving while a pulse or gap is running are queued in a
// saturating counter; triggers beyond MAX_PEND are dropped and flagged.
// MAX_PEND must be at least 1.
module estirador_pulso #(
    parameter int ANCHO_W  = 8,
    parameter int MAX_PEND = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    estirador_pulso_if.slave bus
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PEND);
    localparam logic [PEND_W-1:0]  PEND_UNO = PEND_W'(1);
    localparam logic [ANCHO_W-1:0] CNT_UNO  = ANCHO_W'(1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,  // idle
        ALTO   = 2'd1,  // pulse high
        BAJO   = 2'd2   // mandatory low gap
    } estado_e;

    estado_e            estado_q, estado_d;
    logic [ANCHO_W-1:0] cnt_q, cnt_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               salida_q, salida_d;
    logic               ocupado_q, ocupado_d;
    logic               fin_q, fin_d;
    logic               perdido_q, perdido_d;

    // Start opportunity flag and the gap reload value (zero gap acts as one).
    logic               oportunidad;
    logic [ANCHO_W-1:0] sep_carga;

    // Next state of the whole engine: queueing, pulse/gap timing, starts.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        salida_d    = 1'b0;
        fin_d       = 1'b0;
        perdido_d   = 1'b0;
        oportunidad = 1'b0;
        sep_carga   = (bus.Separacion == '0) ? '0 : bus.Separacion - CNT_UNO;

        unique case (estado_q)
            REPOSO: begin
                oportunidad = 1'b1;
            end

            ALTO: begin
                // Triggers during the pulse are queued or, if full, dropped.
                if (bus.Disparo) begin
                    if (pend_q == PEND_MAX) begin
                        perdido_d = 1'b1;
                    end else begin
                        pend_d = pend_q + PEND_UNO;
                    end
                end
                if (cnt_q == '0) begin
                    // Last high cycle: Separacion is sampled here.
                    estado_d = BAJO;
                    cnt_d    = sep_carga;
                    fin_d    = 1'b1;
                end else begin
                    cnt_d    = cnt_q - CNT_UNO;
                    salida_d = 1'b1;
                end
            end

            BAJO: begin
                if (cnt_q == '0) begin
                    // Gap over: this cycle may launch the next pulse.
                    oportunidad = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_UNO;
                    if (bus.Disparo) begin
                        if (pend_q == PEND_MAX) begin
                            perdido_d = 1'b1;
                        end else begin
                            pend_d = pend_q + PEND_UNO;
                        end
                    end
                end
            end

            default: begin
                estado_d = REPOSO;
                cnt_d    = '0;
                pend_d   = '0;
            end
        endcase

        // A start opportunity consumes the oldest trigger: a queued one if any,
        // otherwise the live Disparo. A live Disparo alongside a consumed queued
        // trigger takes the freed slot, so it is never reported as lost.
        if (oportunidad) begin
            if (!bus.Disparo && pend_q == '0) begin
                estado_d = REPOSO;
            end else if (bus.Duracion == '0) begin
                // Zero duration flushes everything and produces no pulse.
                estado_d = REPOSO;
                cnt_d    = '0;
                pend_d   = '0;
            end else begin
                estado_d = ALTO;
                cnt_d    = bus.Duracion - CNT_UNO;
                salida_d = 1'b1;
                if (pend_q != '0 && !bus.Disparo) begin
                    pend_d = pend_q - PEND_UNO;
                end
            end
        end

        // Busy reflects the state we are about to enter, so it drops on the
        // same edge that lands in REPOSO with an empty queue.
        ocupado_d = (estado_d != REPOSO) || (pend_d != '0);
    end

    // State, counters and registered outputs; all clear asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            pend_q    <= '0;
            salida_q  <= 1'b0;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
            perdido_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            salida_q  <= salida_d;
            ocupado_q <= ocupado_d;
            fin_q     <= fin_d;
            perdido_q <= perdido_d;
        end
    end

    assign bus.Salida  = salida_q;
    assign bus.Ocupado = ocupado_q;
    assign bus.Fin     = fin_q;
    assign bus.Perdido = perdido_q;

endmodule

// File: tb/tb_estirador_pulso.sv
// Self-checking bench for estirador_pulso: a per-edge vector table, directed
// multi-cycle corner cases, and randomized traffic against a timestamp model.
module tb_estirador_pulso;

    localparam int ANCHO_W  = 8;
    localparam int MAX_PEND = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    estirador_pulso_if #(.ANCHO_W(ANCHO_W)) bus ();

    estirador_pulso #(
        .ANCHO_W (ANCHO_W),
        .MAX_PEND(MAX_PEND)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    int   tests = 0;
    int   fails = 0;
    int   n_rise = 0;
    int   n_fin  = 0;
    int   n_lost = 0;
    logic sal_prev = 1'b0;

    // Reference model: absolute edge timestamps instead of down-counters.
    int m_hi;    // edge at which the running pulse ends, -1 if none
    int m_opp;   // first edge at which a new pulse may start
    int m_pend;  // triggers waiting

    typedef struct {
        logic disp;
        int   dur;
        int   sep;
        logic [3:0] exp;  // {Salida, Fin, Ocupado, Perdido} after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic disp, input int dur, input int sep);
        bus.Disparo    = disp;
        bus.Duracion   = ANCHO_W'(dur);
        bus.Separacion = ANCHO_W'(sep);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.Salida && !sal_prev) n_rise++;
        if (bus.Fin) n_fin++;
        if (bus.Perdido) n_lost++;
        sal_prev = bus.Salida;
    endtask

    task automatic clear_counts();
        n_rise   = 0;
        n_fin    = 0;
        n_lost   = 0;
        sal_prev = bus.Salida;
    endtask

    // Run with no triggers until the block goes idle, bounded.
    task automatic drain(input string name, input int budget);
        logic done = 1'b0;
        bus.Disparo = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (!bus.Ocupado) done = 1'b1;
        end
        check({name, "_drained"}, 32'(done), 32'd1);
    endtask

    function automatic vec_t v(input logic disp, input int dur, input int sep, input logic [3:0] exp);
        vec_t r;
        r.disp = disp;
        r.dur  = dur;
        r.sep  = sep;
        r.exp  = exp;
        return r;
    endfunction

    task automatic model_reset();
        m_hi   = -1;
        m_opp  = -1;
        m_pend = 0;
    endtask

    task automatic model_edge(input int t, input logic disp, input int dur, input int sep,
                              output logic [3:0] exp);
        logic fin;
        logic lost;
        fin  = 1'b0;
        lost = 1'b0;
        if (m_hi >= 0) begin
            if (disp) begin
                if (m_pend == MAX_PEND) lost = 1'b1;
                else m_pend++;
            end
            if (t == m_hi) begin
                fin   = 1'b1;
                m_opp = t + ((sep == 0) ? 1 : sep);
                m_hi  = -1;
            end
        end else if (t >= m_opp) begin
            if (disp || m_pend > 0) begin
                if (dur != 0) begin
                    if (m_pend > 0) m_pend = m_pend - 1 + int'(disp);
                    m_hi = t + dur;
                end else begin
                    m_pend = 0;
                end
            end
        end else if (disp) begin
            if (m_pend == MAX_PEND) lost = 1'b1;
            else m_pend++;
        end
        exp = {m_hi >= 0, fin, (m_hi >= 0) || (m_opp > t) || (m_pend > 0), lost};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp;
        int dens;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive(1'b0, 1, 1);
        tick();
        check("rst_salida",  32'(bus.Salida),  32'd0);
        check("rst_ocupado", 32'(bus.Ocupado), 32'd0);
        check("rst_fin",     32'(bus.Fin),     32'd0);
        check("rst_perdido", 32'(bus.Perdido), 32'd0);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        // Single pulse: Duracion=3, Separacion=2.
        vecs.push_back(v(1, 3, 2, 4'b1010));
        vecs.push_back(v(0, 3, 2, 4'b1010));
        vecs.push_back(v(0, 3, 2, 4'b1010));
        vecs.push_back(v(0, 3, 2, 4'b0110));
        vecs.push_back(v(0, 3, 2, 4'b0010));
        vecs.push_back(v(0, 3, 2, 4'b0000));
        vecs.push_back(v(0, 3, 2, 4'b0000));
        // Queued retrigger: Duracion=4, Separacion=0 (acts as 1).
        vecs.push_back(v(1, 4, 0, 4'b1010));
        vecs.push_back(v(0, 4, 0, 4'b1010));
        vecs.push_back(v(1, 4, 0, 4'b1010));
        vecs.push_back(v(0, 4, 0, 4'b1010));
        vecs.push_back(v(0, 4, 0, 4'b0110));
        vecs.push_back(v(0, 4, 0, 4'b1010));
        vecs.push_back(v(0, 4, 0, 4'b1010));
        vecs.push_back(v(0, 4, 0, 4'b1010));
        vecs.push_back(v(0, 4, 0, 4'b1010));
        vecs.push_back(v(0, 4, 0, 4'b0110));
        vecs.push_back(v(0, 4, 0, 4'b0000));
        // Zero duration from idle: nothing at all happens.
        vecs.push_back(v(1, 0, 2, 4'b0000));
        vecs.push_back(v(0, 0, 2, 4'b0000));
        vecs.push_back(v(1, 0, 0, 4'b0000));

        foreach (vecs[i]) begin
            drive(vecs[i].disp, vecs[i].dur, vecs[i].sep);
            tick();
            check($sformatf("vec%0d", i),
                  32'({bus.Salida, bus.Fin, bus.Ocupado, bus.Perdido}), 32'(vecs[i].exp));
        end

        // ---------------- overflow ----------------
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 10, 1);
            tick();
            check($sformatf("ovf_perdido_e%0d", i), 32'(bus.Perdido), 32'(i >= 4));
        end
        drain("ovf", 200);
        check("ovf_lost",   32'(n_lost), 32'd2);
        check("ovf_pulses", 32'(n_rise), 32'd4);
        check("ovf_fins",   32'(n_fin),  32'd4);

        // ---------------- simultaneous consume and trigger ----------------
        clear_counts();
        for (int e = 0; e < 8; e++) begin
            drive(e <= 3 || e == 7, 4, 3);
            tick();
        end
        check("simul_salida",  32'(bus.Salida),  32'd1);
        check("simul_perdido", 32'(bus.Perdido), 32'd0);
        drain("simul", 200);
        check("simul_lost",   32'(n_lost), 32'd0);
        check("simul_pulses", 32'(n_rise), 32'd5);
        check("simul_fins",   32'(n_fin),  32'd5);

        // ---------------- zero duration with queued triggers ----------------
        clear_counts();
        for (int e = 0; e < 3; e++) begin
            drive(1'b1, 5, 2);
            tick();
        end
        drive(1'b0, 0, 2);
        for (int e = 3; e < 7; e++) tick();
        check("zq_busy_e6", 32'(bus.Ocupado), 32'd1);
        tick();
        check("zq_idle_e7",   32'(bus.Ocupado), 32'd0);
        check("zq_salida_e7", 32'(bus.Salida),  32'd0);
        for (int e = 0; e < 6; e++) tick();
        check("zq_pulses", 32'(n_rise),      32'd1);
        check("zq_fins",   32'(n_fin),       32'd1);
        check("zq_still",  32'(bus.Ocupado), 32'd0);

        // ---------------- async reset mid-pulse ----------------
        clear_counts();
        drive(1'b1, 8, 1);
        tick();
        drive(1'b0, 8, 1);
        tick();
        tick();
        check("ar_high_before", 32'(bus.Salida), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_salida_now",  32'(bus.Salida),  32'd0);
        check("ar_ocupado_now", 32'(bus.Ocupado), 32'd0);
        check("ar_fin_now",     32'(bus.Fin),     32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            check($sformatf("ar_idle%0d", e),
                  32'({bus.Salida, bus.Ocupado}), 32'd0);
        end
        check("ar_no_fin", 32'(n_fin), 32'd0);
        drive(1'b1, 2, 1);
        tick();
        check("ar_p_e0", 32'({bus.Salida, bus.Fin}), 32'b10);
        drive(1'b0, 2, 1);
        tick();
        check("ar_p_e1", 32'({bus.Salida, bus.Fin}), 32'b10);
        tick();
        check("ar_p_e2", 32'({bus.Salida, bus.Fin}), 32'b01);
        tick();
        check("ar_p_e3", 32'({bus.Salida, bus.Fin, bus.Ocupado}), 32'b000);

        // ---------------- randomized against the model ----------------
        rst_n = 1'b0;
        drive(1'b0, 1, 1);
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        dens = 30;
        for (int t = 0; t < 3000; t++) begin
            logic disp_r;
            int   dur_r;
            int   sep_r;
            if (t % 200 == 0) dens = (t % 600 == 0) ? 10 : ((t % 400 == 0) ? 70 : 35);
            disp_r = ($urandom_range(0, 99) < dens);
            dur_r  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 5);
            sep_r  = $urandom_range(0, 3);
            drive(disp_r, dur_r, sep_r);
            model_edge(t, disp_r, dur_r, sep_r, exp);
            tick();
            check($sformatf("rand_t%0d", t),
                  32'({bus.Salida, bus.Fin, bus.Ocupado, bus.Perdido}), 32'(exp));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/estirador_pulso.md
# estirador_pulso

Converts single-cycle trigger pulses, typically the output of the rising-edge detector, back into timed level pulses of programmable length. Each pulse is followed by a guaranteed minimum low gap. Triggers that arrive while a pulse or gap is in progress are queued in a saturating counter, and triggers that overflow the queue are reported. The block sits between edge-detected push-button or event strobes and slower consumers (LEDs, display blanking, peripheral enables) that need a minimum pulse width.

## Interface
- ANCHO_W, 8: width of the duration/gap inputs and the internal down-counter.
- MAX_PEND, 3: maximum number of queued triggers; must be ≥1. The pending counter is $clog2(MAX_PEND+1) bits wide.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Disparo  in  1  trigger. Each cycle sampled high counts as one trigger.
- Duracion  in  ANCHO_W  high time in cycles. Sampled each time a pulse starts.
- Separacion  in  ANCHO_W  minimum low time in cycles. Sampled when a pulse ends; a value of 0 is treated as 1.
- Salida  out  1  registered stretched pulse.
- Ocupado  out  1  high when state ≠ REPOSO or pending ≠ 0.
- Fin  out  1  one-cycle strobe on the first low cycle after each pulse.
- Perdido  out  1  one-cycle strobe when a trigger is dropped because the queue is full.

## Operation
- **States:** REPOSO (idle), ALTO (Salida=1), BAJO (gap). Down-counter `cnt`, pending counter `pend`.
- **Start opportunity:** occurs in REPOSO, and in BAJO when cnt==0, if Disparo=1 or pend>0.
  - If Duracion≠0: go to ALTO and load cnt=Duracion−1.
  - If pend>0, the trigger consumed is a queued one (pend decrements). A simultaneous Disparo is then queued, so pend is unchanged net.
  - If Duracion==0: pend is cleared, Disparo is ignored, state goes to REPOSO, and no Salida/Fin/Perdido is produced.
- **ALTO:** cnt decrements each cycle. When cnt==0: go to BAJO, load cnt=max(Separacion,1)−1, and assert Fin for that cycle.
- **BAJO:** cnt decrements each cycle. When cnt==0: take a start opportunity if one is present, otherwise go to REPOSO.
- **Queueing:** Disparo=1 while in ALTO, or in BAJO when cnt≠0, increments pend.
  - If pend==MAX_PEND, the trigger is dropped and Perdido=1 for one cycle.
  - A trigger arriving in the same cycle a queued trigger is consumed is always accepted (no Perdido).
- **Input changes:** Duracion/Separacion changes during a pulse or gap have no effect until the next sample point.
- **Arithmetic:** counters never wrap. All loads are of value−1 from a nonzero operand.

## Timing
- **Reset values (RST_N low):** Salida=0, Ocupado=0, Fin=0, Perdido=0, state=REPOSO, pend=0, cnt=0. Outputs clear immediately, not at the next edge.
- **Reset mid-pulse:** the pulse is aborted with no Fin. After RST_N deasserts, the block idles until the next Disparo.
- **Latency:** Salida rises on the same edge that samples Disparo=1 in REPOSO.
- **Pulse width:** Salida is high for exactly Duracion cycles.
- **Gap:** the low gap is exactly max(Separacion,1) cycles, so the back-to-back period is Duracion+max(Separacion,1).
- **Fin:** high only on the first gap cycle.
- **Perdido:** high on the cycle after the edge that sampled the dropped trigger.
- **Ocupado:** drops on the edge that moves the block to REPOSO with pend=0.

## Test plan
- **Single pulse:** reset, then Duracion=3, Separacion=2, Disparo for 1 cycle at edge 0 -> Salida high after edges 0–2, low at edge 3; Fin=1 for the cycle after edge 3; Ocupado low after edge 5.
- **Queued retrigger:** Duracion=4, Separacion=0, Disparo at edges 0 and 2 -> pulse 1 high edges 0–3, one low cycle, pulse 2 high edges 5–8; two Fin strobes; no Perdido.
- **Overflow:** MAX_PEND=3, Duracion=10, Disparo held high for 6 cycles starting at edge 0 -> pend saturates at 3; Perdido pulses exactly 2 times; 4 pulses total, each followed by Fin.
- **Simultaneous consume and trigger:** pend=3 and Disparo=1 on the edge BAJO reaches cnt==0 -> new pulse starts, pend stays 3, Perdido=0.
- **Zero duration:** Duracion=0, Disparo pulse in REPOSO -> Salida, Fin, Perdido and Ocupado all stay 0. Set Duracion=0 while two triggers are queued -> at gap end pend=0, state REPOSO, no further pulses.
- **Async reset mid-pulse:** Duracion=8, trigger, drop RST_N 3 cycles into the pulse between clock edges -> Salida falls immediately with no Fin. After release, Disparo with Duracion=2 produces a clean 2-cycle pulse.
